// File: rtl/l1_backing_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// l1_backing_memory : line-granular memory responder with fixed ack latency
// Revision: 1.0
// ----------------------------------------------------------------------------
module l1_backing_memory #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int DEPTH      = 512,
   parameter int LATENCY    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_cs_i,
   input  logic                  mem_we_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [LINE_WIDTH-1:0] mem_data_i,
   output logic [LINE_WIDTH-1:0] mem_data_o,
   output logic                  mem_ack_o,
   output logic                  busy_o
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_BUSY = 2'd1;
   localparam logic [1:0] c_ST_ACK  = 2'd2;

   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic [1:0]            r_state;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_we;
   logic [c_IDX_W-1:0]    r_idx;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic [LINE_WIDTH-1:0] r_mem [DEPTH];

   logic w_done;
   logic w_commit;
   logic w_unused_addr;

   assign w_done   = (r_state == c_ST_BUSY) && (r_cnt == '0);
   assign w_commit = w_done && r_we;

   // Offset bits and bits above the line index are don't-care (addresses alias).
   assign w_unused_addr = ^mem_addr_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_ST_IDLE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= '0;
         mem_data_o <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (mem_cs_i) begin
                  r_we    <= mem_we_i;
                  r_idx   <= mem_addr_i[5 +: c_IDX_W];
                  r_wdata <= mem_data_i;
                  r_cnt   <= c_CNT_LOAD;
                  r_state <= c_ST_BUSY;
               end
            end
            c_ST_BUSY: begin
               if (w_done) begin
                  if (!r_we) begin
                     mem_data_o <= r_mem[r_idx];
                  end
                  r_state <= c_ST_ACK;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
            end
            c_ST_ACK: begin
               // Strobe is not sampled here so a held request is never counted twice.
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Array is unreset; a write is lost if reset forces the FSM out of BUSY first.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign mem_ack_o = (r_state == c_ST_ACK);
   assign busy_o    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l1_backing_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l1_backing_memory : directed bench for l1_backing_memory (LATENCY 10 and 1)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_l1_backing_memory;

   localparam int LAT = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cs = 1'b0, we = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] wdata = '0;
   logic [255:0] rdata;
   logic         ack, busy;

   logic         cs1 = 1'b0, we1 = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [255:0] wdata1 = '0;
   logic [255:0] rdata1;
   logic         ack1, busy1;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [255:0] c_A5 = {32{8'hA5}};
   localparam logic [255:0] c_11 = {32{8'h11}};
   localparam logic [255:0] c_22 = {32{8'h22}};
   localparam logic [255:0] c_44 = {32{8'h44}};
   localparam logic [255:0] c_55 = {32{8'h55}};
   localparam logic [255:0] c_66 = {32{8'h66}};
   localparam logic [255:0] c_77 = {32{8'h77}};
   localparam logic [255:0] c_99 = {32{8'h99}};
   localparam logic [255:0] c_5A = {32{8'h5A}};
   localparam logic [255:0] c_C3 = {32{8'hC3}};

   l1_backing_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .DEPTH(512), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .mem_cs_i(cs), .mem_we_i(we), .mem_addr_i(addr),
      .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack), .busy_o(busy));

   l1_backing_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .DEPTH(512), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_cs_i(cs1), .mem_we_i(we1), .mem_addr_i(addr1),
      .mem_data_i(wdata1), .mem_data_o(rdata1), .mem_ack_o(ack1), .busy_o(busy1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=10 instance; returns ack latency or -1.
   task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                      output int lat, output logic [255:0] rd, output logic ack_after);
      cs = 1'b1; we = w; addr = a; wdata = d;
      tick;
      lat = -1;
      for (int n = 1; n <= 4 * LAT; n++) begin
         tick;
         if (ack) begin
            lat = n;
            break;
         end
      end
      rd = rdata;
      cs = 1'b0; we = 1'b0;
      tick;
      ack_after = ack;
   endtask

   task automatic test_reset;
      int lat;
      cs = 1'b1; we = 1'b0; addr = 32'h0;
      repeat (3) tick;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
      n_checks++; if (rdata !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
      #3 rst = 1'b0;
      tick;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL capture_after_reset: busy got %b expected 1", busy); end
      lat = -1;
      for (int n = 1; n <= 4 * LAT; n++) begin
         tick;
         if (ack) begin
            lat = n;
            break;
         end
      end
      cs = 1'b0;
      tick;
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL first_read_latency: got %0d expected %0d", lat, LAT); end
   endtask

   task automatic test_write_read;
      int lat;
      logic [255:0] rd;
      logic aa;
      req(1'b1, 32'h0000_0040, c_A5, lat, rd, aa);
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (aa !== 1'b0) begin n_errors++; $display("FAIL write_ack_width: ack got %b expected 0", aa); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL write_busy_after: got %b expected 0", busy); end
      req(1'b0, 32'h0000_0040, '0, lat, rd, aa);
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (rd !== c_A5) begin n_errors++; $display("FAIL read_data: got %h expected %h", rd, c_A5); end
      tick;
      n_checks++; if (rdata !== c_A5) begin n_errors++; $display("FAIL read_data_held: got %h expected %h", rdata, c_A5); end
   endtask

   task automatic test_alias;
      int lat;
      logic [255:0] rd;
      logic aa;
      req(1'b1, 32'h0000_0020, c_11, lat, rd, aa);
      n_checks++; if (rdata !== c_A5) begin n_errors++; $display("FAIL write_keeps_data: got %h expected %h", rdata, c_A5); end
      req(1'b1, 32'h0000_4020, c_22, lat, rd, aa);
      req(1'b0, 32'h0000_0020, '0, lat, rd, aa);
      n_checks++; if (rd !== c_22) begin n_errors++; $display("FAIL alias_read: got %h expected %h", rd, c_22); end
      req(1'b0, 32'h0000_003F, '0, lat, rd, aa);
      n_checks++; if (rd !== c_22) begin n_errors++; $display("FAIL alias_offset_read: got %h expected %h", rd, c_22); end
   endtask

   task automatic test_held_strobe;
      int acks;
      int pos[3];
      pos = '{-1, -1, -1};
      acks = 0;
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0040;
      for (int t = 1; t <= 1 + LAT + 2 * (LAT + 2) + 1; t++) begin
         tick;
         if (ack) begin
            if (acks < 3) pos[acks] = t;
            acks++;
         end
      end
      cs = 1'b0;
      tick;
      n_checks++; if (acks !== 3) begin n_errors++; $display("FAIL held_ack_count: got %0d expected 3", acks); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (pos[i] !== 1 + LAT + i * (LAT + 2)) begin
            n_errors++;
            $display("FAIL held_ack_pos%0d: got %0d expected %0d", i, pos[i], 1 + LAT + i * (LAT + 2));
         end
      end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL held_no_extra: busy got %b expected 0", busy); end
      n_checks++; if (rdata !== c_A5) begin n_errors++; $display("FAIL held_data: got %h expected %h", rdata, c_A5); end
   endtask

   task automatic test_input_churn;
      int lat;
      logic [255:0] rd;
      logic aa;
      req(1'b1, 32'h0000_0080, c_44, lat, rd, aa);
      req(1'b1, 32'h0000_00A0, c_55, lat, rd, aa);
      req(1'b1, 32'h0000_00C0, c_66, lat, rd, aa);
      req(1'b1, 32'h0000_00E0, c_77, lat, rd, aa);
      cs = 1'b1; we = 1'b1; addr = 32'h0000_0080; wdata = c_99;
      tick;
      lat = -1;
      for (int n = 1; n <= 4 * LAT; n++) begin
         addr  = 32'h0000_00A0 + 32'(n % 3) * 32'h20;
         wdata = {8{32'(n) ^ 32'hDEAD_0000}};
         we    = n[0];
         tick;
         if (ack) begin
            lat = n;
            break;
         end
      end
      cs = 1'b0; we = 1'b0;
      tick;
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL churn_latency: got %0d expected %0d", lat, LAT); end
      req(1'b0, 32'h0000_0080, '0, lat, rd, aa);
      n_checks++; if (rd !== c_99) begin n_errors++; $display("FAIL churn_line4: got %h expected %h", rd, c_99); end
      req(1'b0, 32'h0000_00A0, '0, lat, rd, aa);
      n_checks++; if (rd !== c_55) begin n_errors++; $display("FAIL churn_line5: got %h expected %h", rd, c_55); end
      req(1'b0, 32'h0000_00C0, '0, lat, rd, aa);
      n_checks++; if (rd !== c_66) begin n_errors++; $display("FAIL churn_line6: got %h expected %h", rd, c_66); end
      req(1'b0, 32'h0000_00E0, '0, lat, rd, aa);
      n_checks++; if (rd !== c_77) begin n_errors++; $display("FAIL churn_line7: got %h expected %h", rd, c_77); end
   endtask

   task automatic test_reset_mid_write;
      int lat;
      int acks;
      logic [255:0] rd;
      logic aa;
      cs = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = c_5A;
      tick;
      repeat (6) tick;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL midrst_ack: got %b expected 0", ack); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if (rdata !== '0) begin n_errors++; $display("FAIL midrst_data: got %h expected 0", rdata); end
      tick;
      cs = 1'b0; we = 1'b0;
      tick;
      #2 rst = 1'b0;
      acks = 0;
      for (int n = 0; n < LAT + 5; n++) begin
         tick;
         if (ack) acks++;
      end
      n_checks++; if (acks !== 0) begin n_errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks); end
      req(1'b0, 32'h0000_0040, '0, lat, rd, aa);
      n_checks++; if (rd !== c_A5) begin n_errors++; $display("FAIL midrst_old_value: got %h expected %h", rd, c_A5); end
   endtask

   task automatic test_latency1;
      cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0060; wdata1 = c_C3;
      tick;
      n_checks++; if (busy1 !== 1'b1 || ack1 !== 1'b0) begin n_errors++; $display("FAIL lat1_busy: got busy %b ack %b expected busy 1 ack 0", busy1, ack1); end
      tick;
      n_checks++; if (ack1 !== 1'b1) begin n_errors++; $display("FAIL lat1_write_ack: got %b expected 1", ack1); end
      cs1 = 1'b0; we1 = 1'b0;
      tick;
      n_checks++; if (ack1 !== 1'b0 || busy1 !== 1'b0) begin n_errors++; $display("FAIL lat1_idle: got ack %b busy %b expected 0 0", ack1, busy1); end
      cs1 = 1'b1;
      tick;
      tick;
      n_checks++; if (ack1 !== 1'b1) begin n_errors++; $display("FAIL lat1_read_ack: got %b expected 1", ack1); end
      n_checks++; if (rdata1 !== c_C3) begin n_errors++; $display("FAIL lat1_read_data: got %h expected %h", rdata1, c_C3); end
      cs1 = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_alias;
      test_held_strobe;
      test_input_churn;
      test_reset_mid_write;
      test_latency1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
